// File: rtl/lud_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lud_ctrl_pkg
// Shared definitions for the LUD control-word sequencer:
//   - default BRAM address width and control-word width
//   - index of the "complete" bit inside a control word
//   - FSM state encoding (also exported on debug_state)
// ---------------------------------------------------------------------------
package lud_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_CTRL_WIDTH = 72;

    // A control word with this bit set is the last word of a program.
    localparam int COMPLETE_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_RUN   = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/ctrl_bram_mux.sv
// ---------------------------------------------------------------------------
// ctrl_bram_mux
// Steers the single BRAM port between the host load port and the sequencer.
// The sequencer only ever reads, so its write data and write enable are
// tied off here; a host write can never reach the BRAM unless i_sel is high.
//
// Ports:
//   i_sel          1 = host owns the BRAM, 0 = sequencer owns it
//   i_host_addr/din/en/we   host load port
//   o_host_dout    BRAM read data returned to the host
//   i_seq_addr/en  sequencer read request
//   o_bram_addr/din/en/we   BRAM port
//   i_bram_dout    BRAM read data
// ---------------------------------------------------------------------------
module ctrl_bram_mux
    import lud_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
    input  logic                  i_sel,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [CTRL_WIDTH-1:0] i_host_din,
    input  logic                  i_host_en,
    input  logic                  i_host_we,
    output logic [CTRL_WIDTH-1:0] o_host_dout,
    input  logic [ADDR_WIDTH-1:0] i_seq_addr,
    input  logic                  i_seq_en,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic [CTRL_WIDTH-1:0] o_bram_din,
    output logic                  o_bram_en,
    output logic                  o_bram_we,
    input  logic [CTRL_WIDTH-1:0] i_bram_dout
);

    always_comb begin
        if (i_sel) begin
            o_bram_addr = i_host_addr;
            o_bram_din  = i_host_din;
            o_bram_en   = i_host_en;
            o_bram_we   = i_host_en & i_host_we;
        end else begin
            o_bram_addr = i_seq_addr;
            o_bram_din  = '0;
            o_bram_en   = i_seq_en;
            o_bram_we   = 1'b0;
        end
    end

    assign o_host_dout = i_bram_dout;

endmodule

// File: rtl/lud_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// lud_ctrl_sequencer
// Streams control words out of a BRAM to a datapath. The host loads the BRAM
// while the sequencer is idle or done; a run starts when START rises and
// issues words from address 0 upward until a word with the complete bit set
// is issued, or the last BRAM address has been issued (ERROR).
//
// Ports:
//   CLK_100, RST        clock, asynchronous active-low reset
//   START               run request, held high by the host for the whole run
//   STALL               datapath backpressure, freezes word issue
//   COMPLETED           low only while a run is in progress
//   ERROR               last run ended by address exhaustion
//   CTRL_SIGNAL/VALID   issued control word (zero when not valid)
//   WORD_COUNT          words issued in the current or last run
//   host_*              host load port (ignored while a run is active)
//   host_grant          the host owns the BRAM this cycle
//   bram_*              single BRAM port, 1-cycle read latency
//   debug_state         current FSM state
//
// Handshake: a word is transferred on every cycle where CTRL_VALID=1. The
// datapath may refuse the word on offer by raising STALL; CTRL_VALID then
// drops in that same cycle and the identical word is offered again once
// STALL falls. No word is ever offered twice after it has been accepted.
// ---------------------------------------------------------------------------
module lud_ctrl_sequencer
    import lud_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CTRL_WIDTH = DEF_CTRL_WIDTH
) (
    input  logic                  CLK_100,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  STALL,
    output logic                  COMPLETED,
    output logic                  ERROR,
    output logic [CTRL_WIDTH-1:0] CTRL_SIGNAL,
    output logic                  CTRL_VALID,
    output logic [ADDR_WIDTH-1:0] WORD_COUNT,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [CTRL_WIDTH-1:0] host_din,
    input  logic                  host_en,
    input  logic                  host_we,
    output logic [CTRL_WIDTH-1:0] host_dout,
    output logic                  host_grant,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [CTRL_WIDTH-1:0] bram_din,
    output logic                  bram_en,
    output logic                  bram_we,
    input  logic [CTRL_WIDTH-1:0] bram_dout,
    output logic [2:0]            debug_state
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [ADDR_WIDTH-1:0] r_word_count;
    logic [ADDR_WIDTH-1:0] w_next_count;
    logic                  r_error;
    logic                  w_next_error;
    // Set when the word now on bram_dout was read from ADDR_MAX; issuing it
    // without the complete bit ends the run with ERROR instead of wrapping.
    logic                  r_last_addr;
    logic                  w_next_last;

    logic                  w_issue;
    logic                  w_seq_en;
    logic [ADDR_WIDTH-1:0] w_seq_addr;
    logic                  w_host_grant;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_100 or negedge RST) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_word_count <= '0;
            r_error      <= 1'b0;
            r_last_addr  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_addr       <= w_next_addr;
            r_word_count <= w_next_count;
            r_error      <= w_next_error;
            r_last_addr  <= w_next_last;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and sequencer read logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_addr;
        w_next_count = r_word_count;
        w_next_error = r_error;
        w_next_last  = r_last_addr;
        w_issue      = 1'b0;
        w_seq_en     = 1'b0;
        w_seq_addr   = r_addr;

        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_next_state = ST_FETCH;
                    w_next_error = 1'b0;
                end
            end

            ST_FETCH: begin
                if (!START) begin
                    w_next_state = ST_IDLE;
                    w_next_error = 1'b0;
                end else begin
                    // Prime the BRAM pipeline with word 0.
                    w_seq_en     = 1'b1;
                    w_seq_addr   = '0;
                    w_next_addr  = ADDR_ONE;
                    w_next_count = '0;
                    w_next_last  = 1'b0;
                    w_next_state = ST_RUN;
                end
            end

            ST_RUN, ST_HOLD: begin
                if (!START) begin
                    // Abort wins over everything, so nothing is issued.
                    w_next_state = ST_IDLE;
                    w_next_error = 1'b0;
                end else if (STALL) begin
                    // BRAM is disabled, so bram_dout keeps the pending word.
                    w_next_state = ST_HOLD;
                end else begin
                    w_issue      = 1'b1;
                    w_next_count = r_word_count + ADDR_ONE;
                    if (bram_dout[COMPLETE_BIT]) begin
                        w_next_state = ST_DONE;
                    end else if (r_last_addr) begin
                        w_next_state = ST_DONE;
                        w_next_error = 1'b1;
                    end else begin
                        w_seq_en     = 1'b1;
                        w_seq_addr   = r_addr;
                        w_next_last  = (r_addr == ADDR_MAX);
                        // Hold at the top address rather than wrap to 0.
                        if (r_addr != ADDR_MAX) begin
                            w_next_addr = r_addr + ADDR_ONE;
                        end
                        w_next_state = ST_RUN;
                    end
                end
            end

            ST_DONE: begin
                if (!START) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // RST gates the grant so the host cannot touch the BRAM during reset.
    assign w_host_grant = RST & ((r_state == ST_IDLE) || (r_state == ST_DONE));

    assign host_grant  = w_host_grant;
    assign CTRL_VALID  = w_issue;
    assign CTRL_SIGNAL = w_issue ? bram_dout : '0;
    assign COMPLETED   = !((r_state == ST_FETCH) || (r_state == ST_RUN) ||
                           (r_state == ST_HOLD));
    assign ERROR       = r_error;
    // Width follows the address bus, so a run using every address of the
    // BRAM reports a count that has wrapped to 0.
    assign WORD_COUNT  = r_word_count;
    assign debug_state = r_state;

    ctrl_bram_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_bram_mux (
        .i_sel       (w_host_grant),
        .i_host_addr (host_addr),
        .i_host_din  (host_din),
        .i_host_en   (host_en),
        .i_host_we   (host_we),
        .o_host_dout (host_dout),
        .i_seq_addr  (w_seq_addr),
        .i_seq_en    (w_seq_en),
        .o_bram_addr (bram_addr),
        .o_bram_din  (bram_din),
        .o_bram_en   (bram_en),
        .o_bram_we   (bram_we),
        .i_bram_dout (bram_dout)
    );

endmodule

// File: tb/tb_lud_ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lud_ctrl_sequencer
// Bench for lud_ctrl_sequencer with a 16-entry BRAM (ADDR_WIDTH=4). Expected
// control words are queued when a run is launched and checked in order by a
// monitor whenever CTRL_VALID is high.
// ---------------------------------------------------------------------------
module tb_lud_ctrl_sequencer;

    localparam int AW    = 4;
    localparam int CW    = 72;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start     = 1'b0;
    logic          stall     = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [CW-1:0] host_din  = '0;
    logic          host_en   = 1'b0;
    logic          host_we   = 1'b0;

    logic          completed;
    logic          error;
    logic [CW-1:0] ctrl_signal;
    logic          ctrl_valid;
    logic [AW-1:0] word_count;
    logic [CW-1:0] host_dout;
    logic          host_grant;
    logic [AW-1:0] bram_addr;
    logic [CW-1:0] bram_din;
    logic          bram_en;
    logic          bram_we;
    logic [CW-1:0] bram_dout;
    logic [2:0]    debug_state;

    lud_ctrl_sequencer #(
        .ADDR_WIDTH (AW),
        .CTRL_WIDTH (CW)
    ) dut (
        .CLK_100     (clk),
        .RST         (rst_n),
        .START       (start),
        .STALL       (stall),
        .COMPLETED   (completed),
        .ERROR       (error),
        .CTRL_SIGNAL (ctrl_signal),
        .CTRL_VALID  (ctrl_valid),
        .WORD_COUNT  (word_count),
        .host_addr   (host_addr),
        .host_din    (host_din),
        .host_en     (host_en),
        .host_we     (host_we),
        .host_dout   (host_dout),
        .host_grant  (host_grant),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_dout   (bram_dout),
        .debug_state (debug_state)
    );

    // ---------------- BRAM model: 1-cycle read, output held when disabled ----
    logic [CW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            bram_dout <= mem[bram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int            total   = 0;
    int            bad     = 0;
    int            n_valid = 0;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] image [0:DEPTH-1];
    logic [CW-1:0] mon_exp;

    always @(negedge clk) begin
        total++;
        if (ctrl_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word got=%h required=no_word", ctrl_signal);
            end else begin
                mon_exp = exp_q.pop_front();
                if (ctrl_signal !== mon_exp) begin
                    bad++;
                    $display("FAIL word_data got=%h required=%h", ctrl_signal, mon_exp);
                end
            end
        end else if (ctrl_signal !== '0) begin
            bad++;
            $display("FAIL idle_signal got=%h required=0", ctrl_signal);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [CW-1:0] d);
        host_en   = 1'b1;
        host_we   = 1'b1;
        host_addr = a;
        host_din  = d;
        tick();
        host_en   = 1'b0;
        host_we   = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [CW-1:0] d);
        host_en   = 1'b1;
        host_we   = 1'b0;
        host_addr = a;
        tick();
        host_en   = 1'b0;
        d         = host_dout;
    endtask

    // Random words; only word 'last' carries the complete bit (-1: none).
    task automatic load_image(input int n, input int last);
        logic [95:0] r;
        logic [CW-1:0] w;
        for (int i = 0; i < n; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            w = r[CW-1:0];
            w[0] = (i == last);
            image[i] = w;
            host_write(AW'(i), w);
        end
    endtask

    task automatic push_expected(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(image[i]);
    endtask

    task automatic wait_done(input int max_cycles);
        int c;
        c = 0;
        while (debug_state !== 3'd4 && c < max_cycles) begin
            tick();
            c++;
        end
        total++;
        if (debug_state !== 3'd4) begin
            bad++;
            $display("FAIL done_timeout got=%0d required=4", debug_state);
        end
    endtask

    task automatic end_run();
        start = 1'b0;
        tick();
        total++;
        if (debug_state !== 3'd0 || completed !== 1'b1) begin
            bad++;
            $display("FAIL back_to_idle got=%0d/%b required=0/1", debug_state, completed);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        host_en = 1'b1;
        host_we = 1'b1;
        #3;
        total++;
        if (debug_state !== 3'd0 || completed !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got=%0d/%b/%b required=0/1/0", debug_state, completed, error);
        end
        total++;
        if (ctrl_valid !== 1'b0 || ctrl_signal !== '0 || word_count !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%h/%0d required=0/0/0", ctrl_valid, ctrl_signal, word_count);
        end
        total++;
        if (bram_en !== 1'b0 || bram_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_bram got=%b/%b required=0/0", bram_en, bram_we);
        end
        host_en = 1'b0;
        host_we = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (host_grant !== 1'b1) begin
            bad++;
            $display("FAIL idle_grant got=%b required=1", host_grant);
        end
    endtask

    task automatic test_basic_run();
        logic [6:0] vbits;
        logic [6:0] cbits;
        load_image(4, 3);
        push_expected(4);
        n_valid = 0;
        start = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vbits[c] = ctrl_valid;
            cbits[c] = completed;
        end
        total++;
        if (vbits !== 7'b0111100) begin
            bad++;
            $display("FAIL basic_valid_timing got=%b required=0111100", vbits);
        end
        total++;
        if (cbits !== 7'b1000001) begin
            bad++;
            $display("FAIL basic_completed got=%b required=1000001", cbits);
        end
        total++;
        if (word_count !== 4'd4 || error !== 1'b0 || debug_state !== 3'd4) begin
            bad++;
            $display("FAIL basic_end got=%0d/%b/%0d required=4/0/4", word_count, error, debug_state);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_drain got=%0d required=0", exp_q.size());
        end
        tick();
        end_run();
    endtask

    task automatic test_stall();
        load_image(4, 3);
        push_expected(4);
        n_valid = 0;
        start = 1'b1;
        tick();
        tick();
        tick();
        stall = 1'b1;
        @(negedge clk);
        total++;
        if (ctrl_valid !== 1'b0 || bram_en !== 1'b0) begin
            bad++;
            $display("FAIL stall_freeze got=%b/%b required=0/0", ctrl_valid, bram_en);
        end
        tick();
        total++;
        if (debug_state !== 3'd3) begin
            bad++;
            $display("FAIL stall_hold got=%0d required=3", debug_state);
        end
        tick();
        tick();
        stall = 1'b0;
        wait_done(20);
        total++;
        if (n_valid != 4 || word_count !== 4'd4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL stall_words got=%0d/%0d/%0d required=4/4/0", n_valid, word_count, exp_q.size());
        end
        end_run();
    endtask

    task automatic test_host_blocked();
        logic [CW-1:0] d;
        load_image(4, 3);
        push_expected(4);
        n_valid = 0;
        start = 1'b1;
        tick();
        tick();
        host_en   = 1'b1;
        host_we   = 1'b1;
        host_addr = 4'd1;
        host_din  = ~image[1];
        @(negedge clk);
        total++;
        if (host_grant !== 1'b0 || bram_we !== 1'b0) begin
            bad++;
            $display("FAIL run_grant got=%b/%b required=0/0", host_grant, bram_we);
        end
        tick();
        host_en = 1'b0;
        host_we = 1'b0;
        wait_done(20);
        total++;
        if (n_valid != 4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL blocked_words got=%0d/%0d required=4/0", n_valid, exp_q.size());
        end
        end_run();
        host_read(4'd1, d);
        total++;
        if (d !== image[1]) begin
            bad++;
            $display("FAIL bram_unchanged got=%h required=%h", d, image[1]);
        end
    endtask

    task automatic test_exhaustion();
        load_image(DEPTH, -1);
        push_expected(DEPTH);
        n_valid = 0;
        start = 1'b1;
        wait_done(40);
        total++;
        if (n_valid != DEPTH || error !== 1'b1 || completed !== 1'b1) begin
            bad++;
            $display("FAIL exhaust_end got=%0d/%b/%b required=16/1/1", n_valid, error, completed);
        end
        repeat (3) tick();
        total++;
        if (n_valid != DEPTH || exp_q.size() != 0 || debug_state !== 3'd4) begin
            bad++;
            $display("FAIL exhaust_no_wrap got=%0d/%0d/%0d required=16/0/4", n_valid, exp_q.size(), debug_state);
        end
        end_run();
    endtask

    task automatic test_abort();
        load_image(8, 7);
        push_expected(2);
        n_valid = 0;
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL error_kept_idle got=%b required=1", error);
        end
        start = 1'b1;
        tick();
        total++;
        if (error !== 1'b0 || debug_state !== 3'd1) begin
            bad++;
            $display("FAIL error_clear_fetch got=%b/%0d required=0/1", error, debug_state);
        end
        tick();
        tick();
        tick();
        start = 1'b0;
        @(negedge clk);
        total++;
        if (ctrl_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_issue got=%b required=0", ctrl_valid);
        end
        tick();
        total++;
        if (debug_state !== 3'd0 || completed !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle got=%0d/%b/%b required=0/1/0", debug_state, completed, error);
        end
        repeat (3) tick();
        total++;
        if (n_valid != 2 || exp_q.size() != 0 || word_count !== 4'd2) begin
            bad++;
            $display("FAIL abort_words got=%0d/%0d/%0d required=2/0/2", n_valid, exp_q.size(), word_count);
        end
    endtask

    task automatic test_reset_mid_run();
        load_image(6, 5);
        push_expected(6);
        n_valid = 0;
        start = 1'b1;
        tick();
        tick();
        tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (debug_state !== 3'd0 || completed !== 1'b1 || error !== 1'b0 || word_count !== '0) begin
            bad++;
            $display("FAIL midrst_state got=%0d/%b/%b/%0d required=0/1/0/0", debug_state, completed, error, word_count);
        end
        total++;
        if (ctrl_valid !== 1'b0 || ctrl_signal !== '0 || bram_en !== 1'b0 || bram_we !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs got=%b/%h/%b/%b required=0/0/0/0", ctrl_valid, ctrl_signal, bram_en, bram_we);
        end
        exp_q.delete();
        start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (n_valid != 2) begin
            bad++;
            $display("FAIL midrst_issued got=%0d required=2", n_valid);
        end
        push_expected(6);
        n_valid = 0;
        start = 1'b1;
        wait_done(20);
        total++;
        if (n_valid != 6 || word_count !== 4'd6 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL restart_words got=%0d/%0d/%0d required=6/6/0", n_valid, word_count, exp_q.size());
        end
        end_run();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_run();
        test_stall();
        test_host_blocked();
        test_exhaustion();
        test_abort();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lud_ctrl_sequencer.md
LUD_CTRL_SEQUENCER -- requirements
Module: lud_ctrl_sequencer

Parameters
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 12: control-word BRAM address width.
REQ-002 The block SHALL take parameter CTRL_WIDTH, default 72: control-word width; bit 0 is the complete bit.

Interface
REQ-003 CLK_100  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 START  in  1  run request; level-held by host for the whole run.
REQ-006 STALL  in  1  datapath backpressure; freezes word issue.
REQ-007 COMPLETED  out  1  low only while a run is in progress.
REQ-008 ERROR  out  1  run ended by address exhaustion, not by the complete bit.
REQ-009 CTRL_SIGNAL  out  CTRL_WIDTH  issued control word; all-zero when CTRL_VALID=0.
REQ-010 CTRL_VALID  out  1  CTRL_SIGNAL holds a new word this cycle.
REQ-011 WORD_COUNT  out  ADDR_WIDTH  number of words issued in the current or last run.
REQ-012 host_addr / host_din / host_en / host_we  in  ADDR_WIDTH / CTRL_WIDTH / 1 / 1  host load port.
REQ-013 host_dout  out  CTRL_WIDTH  BRAM read data returned to the host.
REQ-014 host_grant  out  1  the host owns the BRAM this cycle.
REQ-015 bram_addr / bram_din / bram_en / bram_we  out  ADDR_WIDTH / CTRL_WIDTH / 1 / 1  single BRAM port.
REQ-016 bram_dout  in  CTRL_WIDTH  BRAM data; 1-cycle read latency; held while bram_en=0.
REQ-017 debug_state  out  3  current FSM state encoding.

Function
REQ-018 The FSM SHALL have the states IDLE=0, FETCH=1, RUN=2, HOLD=3 and DONE=4.
REQ-019 IDLE: host_grant=1; BRAM ports = host ports; COMPLETED=1; START=1 -> FETCH.
REQ-020 FETCH: bram_addr=0, bram_en=1, bram_we=0; address register <= 1; WORD_COUNT <= 0; COMPLETED=0 -> RUN.
REQ-021 RUN with STALL=0: CTRL_VALID=1; CTRL_SIGNAL=bram_dout; bram_en=1 at the address register; address register increments; WORD_COUNT increments.
REQ-022 RUN with STALL=1: CTRL_VALID=0; bram_en=0; address register held -> HOLD.
REQ-023 HOLD: same outputs as a stalled RUN; STALL=0 -> RUN, where the held word is issued exactly once.
REQ-024 Host access SHALL be ignored in FETCH, RUN and HOLD; host_grant=0; bram_we SHALL never be 1 in these states.
REQ-025 An issued word with bit 0 = 1 SHALL be the last word issued; next state DONE.
REQ-026 An issued word read from address 2^ADDR_WIDTH-1 with bit 0 = 0 SHALL cause next state DONE with ERROR=1; the address SHALL never wrap to 0.
REQ-027 DONE: COMPLETED=1; host_grant=1; WORD_COUNT and ERROR held; START=0 -> IDLE.
REQ-028 START=0 in FETCH, RUN or HOLD SHALL abort to IDLE next cycle with no further word issued; ERROR=0.
REQ-029 Complete bit and STALL in the same cycle: STALL has priority and the word is re-issued later; DONE follows that issue.
REQ-030 ERROR SHALL be cleared on the IDLE->FETCH transition.

Reset
REQ-031 While RST=0, state SHALL be IDLE.
REQ-032 While RST=0, the address register and WORD_COUNT SHALL be 0.
REQ-033 While RST=0, ERROR=0, CTRL_VALID=0 and CTRL_SIGNAL=0.
REQ-034 While RST=0, COMPLETED=1 and bram_en=bram_we=0.
REQ-035 Reset asserted mid-run SHALL abort immediately with no word issued afterwards.

Structure
REQ-036 State encodings and the complete-bit index (0) SHALL live in a shared package lud_ctrl_pkg, with ADDR_WIDTH and CTRL_WIDTH defaults.
REQ-037 The BRAM mux SHALL be one sub-module, ctrl_bram_mux, selected by host_grant.
REQ-038 The FSM, address counter and WORD_COUNT SHALL remain in the top module.

Verification
REQ-039 Load words at 0..3 with word 3 bit0=1; raise START -> CTRL_VALID 1 for 4 consecutive cycles beginning 2 cycles after START; COMPLETED=1 on the cycle after word 3; WORD_COUNT=4.
REQ-040 Same image, STALL=1 for 3 cycles during word 1 -> words 0,1,2,3 issued each exactly once, in order; WORD_COUNT=4.
REQ-041 Host write with host_we=1 while in RUN -> BRAM contents unchanged; host_grant=0.
REQ-042 ADDR_WIDTH=4 with no complete bit set -> 16 words issued; ERROR=1; COMPLETED=1; no wrap to 0.
REQ-043 START dropped after 2 words -> IDLE next cycle; no further CTRL_VALID; COMPLETED=1.
REQ-044 RST=0 mid-run -> all outputs at reset values immediately; a new START from IDLE restarts at address 0.
